// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the transmit scheduler: FSM encoding,
// step-divider reload values and parameter defaults.
package tx_sched_pkg;

    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_ARB  = 4'b0010;
    localparam logic [3:0] ST_SEND = 4'b0100;
    localparam logic [3:0] ST_GAP  = 4'b1000;

    typedef enum logic [3:0] {
        S_IDLE = ST_IDLE,
        S_ARB  = ST_ARB,
        S_SEND = ST_SEND,
        S_GAP  = ST_GAP
    } state_t;

    localparam logic [2:0] DIV_RELOAD_10G  = 3'd0;
    localparam logic [2:0] DIV_RELOAD_5G   = 3'd1;
    localparam logic [2:0] DIV_RELOAD_2P5G = 3'd3;

    localparam int          IPG_STEPS_DEF = 3;
    localparam logic [15:0] MAX_BYTES_DEF = 16'd9600;

    // Number of qwords needed to carry a byte count, ceil(bytes/8).
    function automatic logic [13:0] qwords(input logic [15:0] bytes);
        return 14'(({1'b0, bytes} + 17'd7) >> 3);
    endfunction

endpackage

// File: rtl/tx_rr_arb.sv
// Combinational round-robin pick: the first requester after 'last', wrapping.
module tx_rr_arb
    import tx_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tx_sched_arb.sv
// Round-robin transmit scheduler feeding tx_xgmii from NREQ FWFT encap FIFOs,
// paced by the speed-mode step enable, with a fixed inter-packet gap.
module tx_sched_arb
    import tx_sched_pkg::*;
#(
    parameter int          NREQ      = 4,
    parameter int          IPG_STEPS = IPG_STEPS_DEF,
    parameter logic [15:0] MAX_BYTES = MAX_BYTES_DEF,
    localparam int IW = $clog2(NREQ)
) (
    input  logic                 clk156,
    input  logic                 rst_,
    input  logic                 mode_10G,
    input  logic                 mode_5G,
    input  logic                 mode_2p5G,
    input  logic                 mode_1G,
    input  logic                 sched_en,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_bytes,
    input  logic [64*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      pop,
    output logic                 rej,
    output logic                 rts,
    output logic [63:0]          rdata,
    output logic [15:0]          rbytes,
    output logic [IW-1:0]        gnt_id,
    output logic                 busy,
    output logic [31:0]          drop_cnt
);

    state_t        state, state_nxt;
    logic [2:0]    div_cnt, div_reload;
    logic          step;
    logic [13:0]   wcnt;
    logic [15:0]   gapcnt;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    logic [63:0] data_a  [NREQ];
    logic [15:0] bytes_a [NREQ];
    logic [15:0] win_bytes;
    logic [13:0] win_qw;
    logic        win_bad;

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign data_a[i]  = req_data[64*i +: 64];
        assign bytes_a[i] = req_bytes[16*i +: 16];
    end

    tx_rr_arb #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .last    (gnt_id),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    assign step      = (div_cnt == 3'd0);
    assign win_bytes = bytes_a[arb_idx];
    assign win_qw    = qwords(win_bytes);
    assign win_bad   = (win_bytes == 16'd0) || (win_bytes > MAX_BYTES);

    // Mode is only sampled while idle so a packet and its gap keep one pace.
    always_ff @(posedge clk156) begin
        if (!rst_) begin
            div_cnt    <= DIV_RELOAD_10G;
            div_reload <= DIV_RELOAD_10G;
        end else begin
            if (state == S_IDLE) begin
                if (mode_10G || mode_1G) div_reload <= DIV_RELOAD_10G;
                else if (mode_5G)        div_reload <= DIV_RELOAD_5G;
                else if (mode_2p5G)      div_reload <= DIV_RELOAD_2P5G;
            end
            div_cnt <= step ? div_reload : div_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk156) begin
        if (!rst_) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (step) begin
            case (state)
                S_IDLE: if (sched_en && (req != '0)) state_nxt = S_ARB;
                S_ARB: begin
                    if (!arb_any || win_bad)  state_nxt = S_IDLE;
                    else if (win_qw == 14'd1) state_nxt = S_GAP;
                    else                      state_nxt = S_SEND;
                end
                S_SEND: if (wcnt <= 14'd1) state_nxt = S_GAP;
                S_GAP:  if (gapcnt <= 16'd1) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // The grant step already carries the first qword, so wcnt counts what is left.
    always_ff @(posedge clk156) begin
        if (!rst_) begin
            rts      <= 1'b0;
            rdata    <= 64'h0;
            rbytes   <= 16'h0;
            pop      <= '0;
            rej      <= 1'b0;
            gnt_id   <= IW'(NREQ - 1);
            busy     <= 1'b0;
            drop_cnt <= 32'h0;
            wcnt     <= '0;
            gapcnt   <= '0;
        end else begin
            pop  <= '0;
            rej  <= 1'b0;
            rts  <= 1'b0;
            busy <= (state_nxt != S_IDLE);
            if (step) begin
                case (state)
                    S_ARB: if (arb_any) begin
                        gnt_id <= arb_idx;
                        pop    <= arb_gnt;
                        if (win_bad) begin
                            rej <= 1'b1;
                            if (drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
                        end else begin
                            rts    <= 1'b1;
                            rbytes <= win_bytes;
                            rdata  <= data_a[arb_idx];
                            wcnt   <= win_qw - 14'd1;
                            gapcnt <= 16'(IPG_STEPS);
                        end
                    end
                    S_SEND: begin
                        rdata  <= data_a[gnt_id];
                        pop    <= NREQ'(1) << gnt_id;
                        wcnt   <= wcnt - 14'd1;
                        gapcnt <= 16'(IPG_STEPS);
                    end
                    S_GAP: gapcnt <= gapcnt - 16'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_sched_arb.sv
// Bench for tx_sched_arb: FWFT source models, a packet scoreboard checked
// on every negedge, a vector table of single-source runs and directed corner cases.
module tb_tx_sched_arb;

    localparam int NREQ = 4;
    localparam int IPG  = 3;
    localparam int IW   = $clog2(NREQ);

    logic                clk156 = 1'b0;
    logic                rst_;
    logic                mode_10G, mode_5G, mode_2p5G, mode_1G;
    logic                sched_en;
    logic [NREQ-1:0]     req;
    logic [16*NREQ-1:0]  req_bytes;
    logic [64*NREQ-1:0]  req_data;
    logic [NREQ-1:0]     pop;
    logic                rej, rts, busy;
    logic [63:0]         rdata;
    logic [15:0]         rbytes;
    logic [IW-1:0]       gnt_id;
    logic [31:0]         drop_cnt;

    tx_sched_arb #(.NREQ(NREQ), .IPG_STEPS(IPG), .MAX_BYTES(16'd9600)) dut (
        .clk156(clk156), .rst_(rst_), .mode_10G(mode_10G), .mode_5G(mode_5G),
        .mode_2p5G(mode_2p5G), .mode_1G(mode_1G), .sched_en(sched_en), .req(req),
        .req_bytes(req_bytes), .req_data(req_data), .pop(pop), .rej(rej), .rts(rts),
        .rdata(rdata), .rbytes(rbytes), .gnt_id(gnt_id), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk156 = ~clk156;

    // Source model: per-source packet list; the FWFT head shows the next qword
    // as soon as pop is seen, and a packet retires on its last pop or on rej.
    logic [15:0] lens [NREQ][8];
    int          loaded [NREQ];
    int          done_n [NREQ];
    int          wpos [NREQ];
    logic [31:0] sptr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req[i]                = (loaded[i] != done_n[i]);
            req_bytes[16*i +: 16] = lens[i][done_n[i] % 8];
            req_data[64*i +: 64]  = {8'hA0 + 8'(i), 24'h0, sptr[i] + 32'(pop[i])};
        end
    end

    always @(posedge clk156) begin
        for (int i = 0; i < NREQ; i++) begin
            if (!rst_) begin
                sptr[i]   <= 32'h0;
                wpos[i]   <= 0;
                done_n[i] <= loaded[i];
            end else if (pop[i]) begin
                sptr[i] <= sptr[i] + 32'd1;
                if (rej || (wpos[i] + 1 >= (int'(lens[i][done_n[i] % 8]) + 7) / 8)) begin
                    wpos[i]   <= 0;
                    done_n[i] <= done_n[i] + 1;
                end else begin
                    wpos[i] <= wpos[i] + 1;
                end
            end
        end
    end

    typedef struct { int src; logic [15:0] bytes; bit rej; } exp_t;
    typedef struct { int mode; int src; logic [15:0] bytes; int npk; int pitch; int lat; bit rej; } vec_t;

    exp_t        sb [$];
    int          checks = 0, fails = 0;
    int          cyc = 0, run_id = 0, last_run = -1, pitch = 1;
    int          cur_src = 0, words = 0, exp_words = 0;
    logic [15:0] cur_bytes = 16'h0;
    bit          pkt_open = 1'b0;
    int          last_pop_cyc = 0, last_word_cyc = 0, first_rts_cyc = 0;
    logic [63:0] last_rdata = 64'h0;
    int          exp_ptr [NREQ];
    int          exp_drop = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        fails++;
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic monitor();
        exp_t        e;
        logic [63:0] w;
        if (!rst_) return;
        if (rej) begin
            if (sb.size() == 0) fail_now("unexpected_rej", 64'(pop), 64'h0);
            else begin
                e = sb.pop_front();
                chk("rej_flag", 64'(rej), 64'(e.rej));
                chk("rej_pop", 64'(pop), 64'(1) << e.src);
                chk("rej_gnt_id", 64'(gnt_id), 64'(e.src));
                chk("rej_no_rts", 64'(rts), 64'h0);
                exp_ptr[e.src]++;
            end
        end else if (rts) begin
            if (pkt_open) chk("words", 64'(words), 64'(exp_words));
            if (sb.size() == 0) fail_now("unexpected_rts", 64'(gnt_id), 64'h0);
            else begin
                e = sb.pop_front();
                chk("rts_flag", 64'(rej), 64'(e.rej));
                chk("gnt_id", 64'(gnt_id), 64'(e.src));
                chk("rbytes", 64'(rbytes), 64'(e.bytes));
                if (last_run == run_id) chk("ipg", 64'(cyc - last_word_cyc), 64'((IPG + 2) * pitch));
                else first_rts_cyc = cyc;
                last_run  = run_id;
                cur_src   = e.src;
                cur_bytes = e.bytes;
                words     = 0;
                exp_words = (int'(e.bytes) + 7) / 8;
                pkt_open  = 1'b1;
            end
        end
        if (pop != '0 && !rej) begin
            if (!pkt_open) fail_now("extra_pop", 64'(pop), 64'h0);
            else begin
                w = {8'hA0 + 8'(cur_src), 24'h0, 32'(exp_ptr[cur_src])};
                chk("pop_src", 64'(pop), 64'(1) << cur_src);
                chk("rdata", rdata, w);
                chk("rbytes_pkt", 64'(rbytes), 64'(cur_bytes));
                if (words > 0) chk("pitch", 64'(cyc - last_pop_cyc), 64'(pitch));
                exp_ptr[cur_src]++;
                words++;
                last_pop_cyc = cyc;
                last_rdata   = rdata;
                if (words == exp_words) begin
                    pkt_open      = 1'b0;
                    last_word_cyc = cyc;
                end
            end
        end else if (pkt_open) begin
            chk("rdata_hold", rdata, last_rdata);
            chk("rbytes_hold", 64'(rbytes), 64'(cur_bytes));
        end
    endtask

    task automatic tick();
        @(negedge clk156);
        cyc++;
        monitor();
    endtask

    task automatic load(int s, logic [15:0] b);
        lens[s][loaded[s] % 8] = b;
        loaded[s]++;
    endtask

    task automatic set_mode(int m);
        mode_10G  = (m == 0);
        mode_5G   = (m == 1);
        mode_2p5G = (m == 2);
        mode_1G   = (m == 3);
        repeat (8) tick();
    endtask

    task automatic drain(int budget);
        int t = 0;
        while (!(sb.size() == 0 && !pkt_open && !busy && req == '0) && t < budget) begin
            tick();
            t++;
        end
        if (t >= budget) fail_now("drain_timeout", 64'(t), 64'(budget));
        repeat (3) tick();
        chk("idle_busy", 64'(busy), 64'h0);
    endtask

    vec_t vt [10];

    initial begin
        int t;
        int load_cyc;
        vt[0] = '{0, 0, 16'd64,   1, 1,  2, 1'b0};
        vt[1] = '{0, 1, 16'd61,   2, 1,  2, 1'b0};
        vt[2] = '{0, 2, 16'd8,    1, 1,  2, 1'b0};
        vt[3] = '{3, 3, 16'd24,   1, 1,  2, 1'b0};
        vt[4] = '{0, 0, 16'd0,    1, 1, -1, 1'b1};
        vt[5] = '{0, 0, 16'd9601, 1, 1, -1, 1'b1};
        vt[6] = '{0, 1, 16'd9600, 1, 1,  2, 1'b0};
        vt[7] = '{1, 0, 16'd16,   2, 2, -1, 1'b0};
        vt[8] = '{2, 1, 16'd16,   2, 4, -1, 1'b0};
        vt[9] = '{0, 2, 16'd1,    3, 1,  2, 1'b0};

        for (int i = 0; i < NREQ; i++) begin
            exp_ptr[i] = 0;
            for (int k = 0; k < 8; k++) lens[i][k] = 16'h0;
        end
        rst_ = 1'b0;
        sched_en = 1'b1;
        mode_10G = 1'b1; mode_5G = 1'b0; mode_2p5G = 1'b0; mode_1G = 1'b0;
        repeat (3) tick();
        chk("rst_rts", 64'(rts), 64'h0);
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_rbytes", 64'(rbytes), 64'h0);
        chk("rst_pop", 64'(pop), 64'h0);
        chk("rst_rej", 64'(rej), 64'h0);
        chk("rst_gnt_id", 64'(gnt_id), 64'(NREQ - 1));
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
        rst_ = 1'b1;
        tick();

        for (int r = 0; r < 10; r++) begin
            set_mode(vt[r].mode);
            run_id++;
            pitch = vt[r].pitch;
            load_cyc = cyc;
            for (int k = 0; k < vt[r].npk; k++) begin
                load(vt[r].src, vt[r].bytes);
                sb.push_back('{vt[r].src, vt[r].bytes, vt[r].rej});
            end
            if (vt[r].rej) exp_drop += vt[r].npk;
            drain(20000);
            if (vt[r].lat >= 0) chk("latency", 64'(first_rts_cyc - load_cyc), 64'(vt[r].lat));
            chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        end

        // Scheduler disabled holds off the grant; dropping it mid-packet does not truncate.
        set_mode(0);
        sched_en = 1'b0;
        run_id++;
        pitch = 1;
        load(1, 16'd64);
        repeat (10) tick();
        chk("disabled_busy", 64'(busy), 64'h0);
        sb.push_back('{1, 16'd64, 1'b0});
        sched_en = 1'b1;
        t = 0;
        while (!pkt_open && t < 20) begin tick(); t++; end
        if (t >= 20) fail_now("en_wait_timeout", 64'(t), 64'd20);
        sched_en = 1'b0;
        drain(200);
        sched_en = 1'b1;

        // Reset while the third qword of a packet is on the bus.
        run_id++;
        load(0, 16'd64);
        sb.push_back('{0, 16'd64, 1'b0});
        t = 0;
        while (!(pkt_open && words == 3) && t < 50) begin tick(); t++; end
        if (t >= 50) fail_now("rst_wait_timeout", 64'(t), 64'd50);
        rst_ = 1'b0;
        tick();
        chk("mid_rst_rts", 64'(rts), 64'h0);
        chk("mid_rst_rdata", rdata, 64'h0);
        chk("mid_rst_rbytes", 64'(rbytes), 64'h0);
        chk("mid_rst_pop", 64'(pop), 64'h0);
        chk("mid_rst_gnt_id", 64'(gnt_id), 64'(NREQ - 1));
        chk("mid_rst_busy", 64'(busy), 64'h0);
        chk("mid_rst_drop_cnt", 64'(drop_cnt), 64'h0);
        tick();
        chk("mid_rst_pop2", 64'(pop), 64'h0);
        sb.delete();
        pkt_open = 1'b0;
        for (int i = 0; i < NREQ; i++) exp_ptr[i] = 0;
        exp_drop = 0;
        rst_ = 1'b1;
        repeat (2) tick();

        // All sources busy: grants rotate 0,1,2,3,0,... starting from the reset pointer.
        run_id++;
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < NREQ; s++) begin
                load(s, 16'd64);
                sb.push_back('{s, 16'd64, 1'b0});
            end
        drain(1000);
        chk("rr_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
